// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor.
// A WIDTH-bit add or subtract is processed CHUNK bits per clock, least
// significant slice first. The carry between slices is kept in a register,
// so only a CHUNK-bit adder sits in the critical path.
// Input and output both use a valid/ready handshake.
// The block reports carry, signed overflow and zero flags.
// Optional feature: define ADDSUB_SATURATE_EN to clamp results that overflow
// to the signed limit.
module chunked_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   // Abort elaboration when the operand width cannot be split into whole slices
   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bx_q, bx_d;          // b, already inverted for subtraction
   logic [WIDTH-1:0] res_q, res_d;        // partial result being assembled
   logic             c_q, c_d;            // inter-slice carry
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;

   logic [31:0]      base_s;
   logic [WIDTH-1:0] slice_mask_s;
   logic [CHUNK-1:0] a_slice_s;
   logic [CHUNK-1:0] bx_slice_s;
   logic [CHUNK:0]   chunk_sum_s;
   logic [WIDTH-1:0] full_s;
   logic             ovf_s;
   logic [WIDTH-1:0] final_s;

   // Slice datapath: add the current slice and merge it into the partial result
   always_comb begin
      base_s       = 32'(idx_q) * 32'(CHUNK);
      slice_mask_s = WIDTH'({CHUNK{1'b1}}) << base_s;
      a_slice_s    = CHUNK'(a_q >> base_s);
      bx_slice_s   = CHUNK'(bx_q >> base_s);
      chunk_sum_s  = {1'b0, a_slice_s} + {1'b0, bx_slice_s} + (CHUNK+1)'(c_q);
      full_s       = (res_q & ~slice_mask_s) |
                     (WIDTH'(chunk_sum_s[CHUNK-1:0]) << base_s);
      ovf_s        = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                     (full_s[WIDTH-1] != a_q[WIDTH-1]);
   end

`ifdef ADDSUB_SATURATE_EN
   // Clamp to the signed limit on overflow; the sign of a selects the direction
   always_comb begin
      if (ovf_s) begin
         if (a_q[WIDTH-1]) begin
            final_s = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            final_s = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         final_s = full_s;
      end
   end
`else
   // Wrapped result is delivered unchanged
   always_comb begin
      final_s = full_s;
   end
`endif

   // Next-state logic for the IDLE -> BUSY -> DONE handshake sequence
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      bx_d        = bx_q;
      res_d       = res_q;
      c_d         = c_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               bx_d    = sub ? ~b : b;
               c_d     = sub;          // +1 completes the two's complement of b
               idx_d   = '0;
               res_d   = '0;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            res_d = full_s;
            c_d   = chunk_sum_s[CHUNK];
            if (idx_q == LAST_IDX) begin
               // Publish result and flags together with out_valid
               sum_d       = final_s;
               carry_d     = chunk_sum_s[CHUNK];
               ovf_d       = ovf_s;
               zero_d      = (final_s == '0);
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         bx_q        <= '0;
         res_q       <= '0;
         c_q         <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         bx_q        <= bx_d;
         res_q       <= res_d;
         c_q         <= c_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub (WIDTH=8, CHUNK=4).
// The expected results come from a plain-arithmetic model of add and subtract.
module tb_chunked_addsub;

   localparam int W = 8;
   localparam int C = 4;
   localparam int N = W / C;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         sub_i     = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] a_i       = '0;
   logic [W-1:0] b_i       = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] sum;
   logic         carry;
   logic         overflow;
   logic         zero;

   int n_checks = 0;
   int n_errors = 0;

   chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .sub       (sub_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed/unsigned arithmetic on whole operands
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic msub, output logic [W-1:0] es,
                                 output logic ec, output logic ev, output logic ez);
      int sa, sb, sr, ua, ub;
      sa = $signed(ma);
      sb = $signed(mb);
      ua = int'(ma);
      ub = int'(mb);
      if (msub) begin
         sr = sa - sb;
         ec = (ua >= ub);
         es = W'(ua - ub);
      end else begin
         sr = sa + sb;
         ec = ((ua + ub) > 255);
         es = W'(ua + ub);
      end
      ev = (sr > 127) || (sr < -128);
`ifdef ADDSUB_SATURATE_EN
      if (ev) es = (sr > 127) ? 8'h7F : 8'h80;
`endif
      ez = (es == 8'h00);
   endfunction

   // One full transaction; stall = cycles out_ready is held low once the result is out
   task automatic run_op(input string tag, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic msub, input int stall);
      logic [W-1:0] es;
      logic ec, ev, ez;
      int cnt;
      model(ma, mb, msub, es, ec, ev, ez);
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a_i = ma; b_i = mb; sub_i = msub; in_valid = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      // Scramble inputs: the in-flight operation must ignore them
      in_valid = 1'b0;
      a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!out_valid && cnt < 20);
      check_eq({tag, "_latency"}, 32'(cnt), 32'(N));
      check_eq({tag, "_sum"}, 32'(sum), 32'(es));
      check_eq({tag, "_carry"}, 32'(carry), 32'(ec));
      check_eq({tag, "_ovf"}, 32'(overflow), 32'(ev));
      check_eq({tag, "_zero"}, 32'(zero), 32'(ez));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check_eq({tag, "_hold_sum"}, 32'(sum), 32'(es));
         check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, "_drain"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_after_sum"}, 32'(sum), 32'(es));
      out_ready = 1'b0;
   endtask

   initial begin : main
      int cnt;
      int seen;
      logic [W-1:0] ra, rb;
      // Reset with in_valid high: nothing may be accepted
      rst_n = 1'b0; in_valid = 1'b1; a_i = 8'h05; b_i = 8'h03;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(sum), 32'h00);
      check_eq("rst_flags", {29'd0, carry, overflow, zero}, 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rel_in_ready", 32'(in_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rel_no_op", 32'(out_valid), 32'd0);

      // Directed cases
      run_op("add_5_3", 8'h05, 8'h03, 1'b0, 0);
      run_op("add_a_2", 8'h0A, 8'h02, 1'b0, 0);
      run_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 0);
      run_op("add_7f_1", 8'h7F, 8'h01, 1'b0, 0);
      run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1);
      run_op("sub_2_7", 8'h02, 8'h07, 1'b1, 0);
      run_op("sub_7_2", 8'h07, 8'h02, 1'b1, 2);
      run_op("sub_80_1", 8'h80, 8'h01, 1'b1, 0);
      run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b1, 0);
      run_op("sub_eq", 8'h33, 8'h33, 1'b1, 0);

      // Backpressure: result held while a new request waits
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      a_i = 8'h05; b_i = 8'h03; sub_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a_i = 8'h10; b_i = 8'h10;          // in_valid stays high
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!out_valid && cnt < 20);
      check_eq("bp_latency", 32'(cnt), 32'(N));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("bp_sum", 32'(sum), 32'h08);
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         check_eq("bp_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;                 // output handshake, no accept here
      check_eq("bp_drain", 32'(out_valid), 32'd0);
      check_eq("bp_idle", 32'(in_ready), 32'd1);
      @(posedge clk); #1;                 // 0x10+0x10 accepted now
      in_valid = 1'b0;
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!out_valid && cnt < 20);
      check_eq("bp2_latency", 32'(cnt), 32'(N));
      check_eq("bp2_sum", 32'(sum), 32'h20);
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Abort: reset at the first BUSY edge
      a_i = 8'h05; b_i = 8'h03; sub_i = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_eq("abort_sum", 32'(sum), 32'h00);
      check_eq("abort_valid", 32'(out_valid), 32'd0);
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_eq("abort_no_result", 32'(seen), 32'd0);
      out_ready = 1'b0;

      // Randomized operations with random backpressure
      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_op($sformatf("rnd%0d", k), ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor for the arithmetic unit; successor to the fixed 4-bit combinational adder.
- Processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry between chunks in a register, so wide adds meet timing.
- Uses a valid/ready handshake on input and output.
- Reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits added per clock; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- carry  output  1  final carry out; for subtraction, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (registered when rst_n=0 at a clk edge):
  - state = IDLE, out_valid = 0.
  - sum, carry, overflow, zero = 0.
  - Chunk index = 0, carry register = 0.
- in_ready = (state == IDLE), combinational; it is 1 from the first edge after reset release.
- States IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - On in_valid && in_ready at an edge: latch a, latch bx = sub ? ~b : b, set carry register = sub, index = 0, go to BUSY.
  - in_valid low: stay in IDLE.
- BUSY:
  - Each edge computes {c, r} = a[idx] + bx[idx] + c over the CHUNK-bit slice idx (LSB slice first).
  - Writes r into the result slice, registers c, and increments idx.
  - After slice N-1, go to DONE with out_valid=1.
- Latency: out_valid rises at the Nth rising edge after the accepting edge (WIDTH=8, CHUNK=4 gives 2; CHUNK=WIDTH gives 1).
- Flags are valid together with out_valid:
  - carry = final c.
  - overflow = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
  - zero = (sum == 0).
- DONE:
  - sum and flags are held stable while out_valid=1 && out_ready=0, for any number of cycles.
  - On out_valid && out_ready at an edge: out_valid -> 0, go to IDLE.
  - No accept in the same cycle as the output handshake; the next operation is accepted no earlier than the following edge.
- After the output handshake, sum and flags keep their last values until the next result is written.
- While BUSY or DONE: in_ready=0, in_valid is ignored, and changes on a/b/sub have no effect on the in-flight operation.
- out_ready while not DONE: ignored.
- Reset mid-operation (BUSY or DONE): the operation is aborted, all registers take their reset values, and no out_valid is produced for the aborted operation.
- All arithmetic is modulo 2^WIDTH; no X propagation from unused slices.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when overflow=1, the result is clamped to the signed limit.
  - Positive overflow (a[MSB]=0): sum = 0 followed by all 1s (0x7F at WIDTH=8).
  - Negative overflow (a[MSB]=1): sum = 1 followed by all 0s (0x80).
  - overflow is still reported as 1; carry is unchanged; zero is computed on the clamped value.
  - The clamp is applied at the DONE transition and adds no extra latency.
- Not defined: the wrapped result is output, no saturation logic is present, and the flags are as above.

Test Plan (WIDTH=8, CHUNK=4):
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> out_valid=0, sum=0x00, all flags 0, in_ready=1 after release, no operation accepted during reset.
- Basic add: a=0x05, b=0x03, sub=0, out_ready=1 -> out_valid at 2nd edge after accept; sum=0x08, carry=0, overflow=0, zero=0. Also a=0x0A, b=0x02 -> sum=0x0C.
- Wrap and overflow:
  - 0xFF+0x01 -> sum=0x00, carry=1, zero=1, overflow=0.
  - 0x7F+0x01 -> sum=0x80, overflow=1 (with ADDSUB_SATURATE_EN: sum=0x7F, overflow=1).
- Subtract:
  - 0x02-0x07 -> sum=0xFB, carry=0, overflow=0.
  - 0x07-0x02 -> sum=0x05, carry=1.
  - 0x80-0x01 -> sum=0x7F, overflow=1 (with ADDSUB_SATURATE_EN: sum=0x80).
- Backpressure: result 0x08 pending, out_ready=0 for 5 cycles, in_valid=1 with a=0x10, b=0x10 -> sum holds 0x08, in_ready=0 throughout. Raise out_ready -> handshake, then 0x10+0x10 accepted on a later edge, giving sum=0x20.
- Abort: accept 0x05+0x03, pull rst_n=0 at the first BUSY edge -> out_valid never asserts, sum=0x00, state IDLE, in_ready=1 after release.
